// File: rtl/key_time_entry.sv
// Turns PS/2 set-2 make codes into a validated HH:MM BCD entry and strobes the
// finished value into either the running clock or the alarm register.
module key_time_entry #(
  parameter int unsigned TIMEOUT = 250_000_000
) (
  input  logic       MCLK,
  input  logic       int_reset,
  input  logic [7:0] key_code,
  input  logic       key_strobe,
  output logic [3:0] ent_ms_hour,
  output logic [3:0] ent_ls_hour,
  output logic [3:0] ent_ms_min,
  output logic [3:0] ent_ls_min,
  output logic [3:0] ent_mask,
  output logic       entry_active,
  output logic       entry_target,
  output logic       load_time,
  output logic       load_alarm,
  output logic       entry_err
);

  // A zero TIMEOUT still needs a one-bit counter; it then never holds 1, so it never expires.
  localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  typedef enum logic [2:0] {
    KEY_NONE, KEY_DIGIT, KEY_TIME, KEY_ALARM, KEY_ENTER, KEY_BKSP, KEY_ESC
  } key_e;

  typedef enum logic {S_IDLE, S_ENTRY} state_e;

  state_e          state_q, state_d;
  logic            break_pend_q, break_pend_d;
  logic            ext_pend_q, ext_pend_d;
  logic            target_q, target_d;
  logic [3:0][3:0] digit_q, digit_d;
  logic [3:0]      mask_q, mask_d;
  logic [2:0]      pos_q, pos_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_time_q, load_time_d;
  logic            load_alarm_q, load_alarm_d;
  logic            err_q, err_d;

  key_e       key_kind;
  logic [3:0] key_val;
  logic       digit_ok;
  logic       make_key;
  logic [1:0] wr_idx;
  logic [1:0] bs_idx;

  always_comb begin
    key_kind = KEY_NONE;
    key_val  = 4'd0;
    case (key_code)
      8'h45, 8'h70: begin key_kind = KEY_DIGIT; key_val = 4'd0; end
      8'h16, 8'h69: begin key_kind = KEY_DIGIT; key_val = 4'd1; end
      8'h1E, 8'h72: begin key_kind = KEY_DIGIT; key_val = 4'd2; end
      8'h26, 8'h7A: begin key_kind = KEY_DIGIT; key_val = 4'd3; end
      8'h25, 8'h6B: begin key_kind = KEY_DIGIT; key_val = 4'd4; end
      8'h2E, 8'h73: begin key_kind = KEY_DIGIT; key_val = 4'd5; end
      8'h36, 8'h74: begin key_kind = KEY_DIGIT; key_val = 4'd6; end
      8'h3D, 8'h6C: begin key_kind = KEY_DIGIT; key_val = 4'd7; end
      8'h3E, 8'h75: begin key_kind = KEY_DIGIT; key_val = 4'd8; end
      8'h46, 8'h7D: begin key_kind = KEY_DIGIT; key_val = 4'd9; end
      8'h2C:        key_kind = KEY_TIME;
      8'h1C:        key_kind = KEY_ALARM;
      8'h5A:        key_kind = KEY_ENTER;
      8'h66:        key_kind = KEY_BKSP;
      8'h76:        key_kind = KEY_ESC;
      default:      key_kind = KEY_NONE;
    endcase
  end

  // Position p writes digit index 3-p (index 3 is ms_hour); backspace clears index 4-p.
  always_comb begin
    wr_idx   = 2'd3 - pos_q[1:0];
    bs_idx   = 2'd3 - 2'(pos_q - 3'd1);
    digit_ok = 1'b1;
    case (pos_q)
      3'd0:    digit_ok = (key_val <= 4'd2);
      3'd1:    digit_ok = (digit_q[3] == 4'd2) ? (key_val <= 4'd3) : 1'b1;
      3'd2:    digit_ok = (key_val <= 4'd5);
      default: digit_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    break_pend_d = break_pend_q;
    ext_pend_d   = ext_pend_q;
    target_d     = target_q;
    digit_d      = digit_q;
    mask_d       = mask_q;
    pos_d        = pos_q;
    cnt_d        = cnt_q;
    load_time_d  = 1'b0;
    load_alarm_d = 1'b0;
    err_d        = 1'b0;
    make_key     = 1'b0;

    // The byte after F0 is a release and never reaches the state machine.
    if (key_strobe) begin
      if (break_pend_q) begin
        break_pend_d = 1'b0;
        ext_pend_d   = 1'b0;
      end else if (key_code == CODE_BREAK) begin
        break_pend_d = 1'b1;
      end else if (key_code == CODE_EXT) begin
        ext_pend_d = 1'b1;
      end else begin
        make_key   = 1'b1;
        ext_pend_d = 1'b0;
      end
    end

    if (state_q == S_ENTRY) begin
      if (key_strobe) begin
        cnt_d = CNT_LOAD;
      end else if (cnt_q == CW'(1)) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    if (make_key) begin
      if (key_kind == KEY_TIME || key_kind == KEY_ALARM) begin
        state_d  = S_ENTRY;
        target_d = (key_kind == KEY_ALARM);
        digit_d  = '0;
        mask_d   = 4'd0;
        pos_d    = 3'd0;
        cnt_d    = CNT_LOAD;
      end else if (state_q == S_ENTRY) begin
        case (key_kind)
          KEY_DIGIT: begin
            if (pos_q == 3'd4 || !digit_ok) begin
              err_d = 1'b1;
            end else begin
              digit_d[wr_idx] = key_val;
              mask_d[wr_idx]  = 1'b1;
              pos_d           = pos_q + 3'd1;
            end
          end
          KEY_BKSP: begin
            if (pos_q != 3'd0) begin
              digit_d[bs_idx] = 4'd0;
              mask_d[bs_idx]  = 1'b0;
              pos_d           = pos_q - 3'd1;
            end
          end
          KEY_ENTER: begin
            if (pos_q == 3'd4) begin
              load_time_d  = !target_q;
              load_alarm_d = target_q;
              state_d      = S_IDLE;
            end else begin
              err_d = 1'b1;
            end
          end
          KEY_ESC: state_d = S_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge MCLK or posedge int_reset) begin
    if (int_reset) begin
      state_q      <= S_IDLE;
      break_pend_q <= 1'b0;
      ext_pend_q   <= 1'b0;
      target_q     <= 1'b0;
      digit_q      <= '0;
      mask_q       <= 4'd0;
      pos_q        <= 3'd0;
      cnt_q        <= '0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      break_pend_q <= break_pend_d;
      ext_pend_q   <= ext_pend_d;
      target_q     <= target_d;
      digit_q      <= digit_d;
      mask_q       <= mask_d;
      pos_q        <= pos_d;
      cnt_q        <= cnt_d;
      load_time_q  <= load_time_d;
      load_alarm_q <= load_alarm_d;
      err_q        <= err_d;
    end
  end

  assign ent_ms_hour  = digit_q[3];
  assign ent_ls_hour  = digit_q[2];
  assign ent_ms_min   = digit_q[1];
  assign ent_ls_min   = digit_q[0];
  assign ent_mask     = mask_q;
  assign entry_active = (state_q == S_ENTRY);
  assign entry_target = target_q;
  assign load_time    = load_time_q;
  assign load_alarm   = load_alarm_q;
  assign entry_err    = err_q;

endmodule
